// File: rtl/l15_amo_initiator_pkg.sv
// Shared encodings and helpers for the L1.5 AMO initiator and the L2 AMO ALU.
package l15_amo_initiator_pkg;

    localparam logic [3:0] L2_AMO_ALU_NOP  = 4'd0;
    localparam logic [3:0] L2_AMO_ALU_ADD  = 4'd1;
    localparam logic [3:0] L2_AMO_ALU_AND  = 4'd2;
    localparam logic [3:0] L2_AMO_ALU_OR   = 4'd3;
    localparam logic [3:0] L2_AMO_ALU_XOR  = 4'd4;
    localparam logic [3:0] L2_AMO_ALU_MAX  = 4'd5;
    localparam logic [3:0] L2_AMO_ALU_MAXU = 4'd6;
    localparam logic [3:0] L2_AMO_ALU_MIN  = 4'd7;
    localparam logic [3:0] L2_AMO_ALU_MINU = 4'd8;
    localparam logic [3:0] L2_AMO_ALU_CAS1 = 4'd9;
    localparam logic [3:0] L2_AMO_ALU_CAS2 = 4'd10;

    localparam logic [2:0] MSG_DATA_SIZE_0B = 3'd0;
    localparam logic [2:0] MSG_DATA_SIZE_1B = 3'd1;
    localparam logic [2:0] MSG_DATA_SIZE_2B = 3'd2;
    localparam logic [2:0] MSG_DATA_SIZE_4B = 3'd3;
    localparam logic [2:0] MSG_DATA_SIZE_8B = 3'd4;

    localparam int unsigned L15_LINE_WIDTH      = 128;
    localparam int unsigned L15_LINE_WIDTH_LOG2 = 7;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} amo_state_e;

    function automatic logic [63:0] byte_rev64(input logic [63:0] d);
        return {<<8{d}};
    endfunction

    function automatic logic [63:0] size_mask(input logic [2:0] size);
        case (size)
            MSG_DATA_SIZE_1B: return 64'h0000_0000_0000_00ff;
            MSG_DATA_SIZE_2B: return 64'h0000_0000_0000_ffff;
            MSG_DATA_SIZE_4B: return 64'h0000_0000_ffff_ffff;
            default:          return 64'hffff_ffff_ffff_ffff;
        endcase
    endfunction

    // Undefined sizes are treated as misaligned so they never reach L2.
    function automatic logic size_misaligned(input logic [2:0] size, input logic [2:0] off);
        case (size)
            MSG_DATA_SIZE_1B: return 1'b0;
            MSG_DATA_SIZE_2B: return off[0];
            MSG_DATA_SIZE_4B: return |off[1:0];
            MSG_DATA_SIZE_8B: return |off;
            default:          return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/l15_amo_initiator_if.sv
// Core-side and L2-side handshake bundle of the AMO initiator.
interface l15_amo_initiator_if #(
    parameter int unsigned LINE_WIDTH = 128
);
    logic                  core_req_val;
    logic                  core_req_rdy;
    logic [3:0]            core_req_op;
    logic [39:0]           core_req_addr;
    logic [2:0]            core_req_size;
    logic [63:0]           core_req_data;
    logic                  l2_req_val;
    logic                  l2_req_rdy;
    logic [3:0]            l2_req_op;
    logic [39:0]           l2_req_addr;
    logic [2:0]            l2_req_size;
    logic [LINE_WIDTH-1:0] l2_req_data;
    logic                  l2_resp_val;
    logic                  l2_resp_rdy;
    logic [LINE_WIDTH-1:0] l2_resp_data;
    logic                  core_resp_val;
    logic                  core_resp_rdy;
    logic [63:0]           core_resp_data;
    logic                  core_resp_err;

    modport master (
        input  core_req_val, core_req_op, core_req_addr, core_req_size, core_req_data,
        output core_req_rdy,
        output l2_req_val, l2_req_op, l2_req_addr, l2_req_size, l2_req_data,
        input  l2_req_rdy,
        input  l2_resp_val, l2_resp_data,
        output l2_resp_rdy,
        output core_resp_val, core_resp_data, core_resp_err,
        input  core_resp_rdy
    );

    modport slave (
        output core_req_val, core_req_op, core_req_addr, core_req_size, core_req_data,
        input  core_req_rdy,
        input  l2_req_val, l2_req_op, l2_req_addr, l2_req_size, l2_req_data,
        output l2_req_rdy,
        output l2_resp_val, l2_resp_data,
        input  l2_resp_rdy,
        input  core_resp_val, core_resp_data, core_resp_err,
        output core_resp_rdy
    );
endinterface

// File: rtl/l15_amo_lane_fmt.sv
// Combinational line formatting: operand -> request line, response line -> sign-extended value.
module l15_amo_lane_fmt
    import l15_amo_initiator_pkg::*;
#(
    parameter bit          SWAP_ENDIANESS  = 1'b1,
    parameter int unsigned LINE_WIDTH      = 128,
    parameter int unsigned LINE_WIDTH_LOG2 = 7
) (
    input  logic [63:0]                operand,
    input  logic [LINE_WIDTH_LOG2-1:0] req_off,
    input  logic [2:0]                 req_size,
    output logic [LINE_WIDTH-1:0]      req_line,
    input  logic [LINE_WIDTH-1:0]      resp_line,
    input  logic [LINE_WIDTH_LOG2-1:0] resp_off,
    input  logic [2:0]                 resp_size,
    output logic [63:0]                resp_value
);
    logic [63:0]           pk_dword;
    logic [LINE_WIDTH-1:0] pk_ext;
    logic [LINE_WIDTH-1:0] up_line;
    logic [63:0]           up_dword;
    logic [63:0]           up_field;

    always_comb begin
        pk_dword = (operand & size_mask(req_size)) << {req_off[2:0], 3'b000};
        if (SWAP_ENDIANESS) pk_dword = byte_rev64(pk_dword);
        pk_ext = '0;
        pk_ext[63:0] = pk_dword;
        req_line = pk_ext << {req_off[LINE_WIDTH_LOG2-1:3], 6'b000000};
    end

    always_comb begin
        up_line  = resp_line >> {resp_off[LINE_WIDTH_LOG2-1:3], 6'b000000};
        up_dword = up_line[63:0];
        if (SWAP_ENDIANESS) up_dword = byte_rev64(up_dword);
        up_field = up_dword >> {resp_off[2:0], 3'b000};
        case (resp_size)
            MSG_DATA_SIZE_1B: resp_value = {{56{up_field[7]}}, up_field[7:0]};
            MSG_DATA_SIZE_2B: resp_value = {{48{up_field[15]}}, up_field[15:0]};
            MSG_DATA_SIZE_4B: resp_value = {{32{up_field[31]}}, up_field[31:0]};
            default:          resp_value = up_field;
        endcase
    end
endmodule

// File: rtl/l15_amo_initiator.sv
// Requester-side AMO engine: one outstanding core AMO, formatted into an L2 line request.
module l15_amo_initiator
    import l15_amo_initiator_pkg::*;
#(
    parameter bit          SWAP_ENDIANESS  = 1'b1,
    parameter int unsigned LINE_WIDTH      = L15_LINE_WIDTH,
    parameter int unsigned LINE_WIDTH_LOG2 = L15_LINE_WIDTH_LOG2
) (
    input logic                 clk,
    input logic                 rst_n,
    l15_amo_initiator_if.master bus
);
    amo_state_e            state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic [39:0]           addr_q, addr_d;
    logic [2:0]            size_q, size_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic [63:0]           resp_data_q, resp_data_d;
    logic                  err_q, err_d;
    logic [LINE_WIDTH-1:0] pack_line;
    logic [63:0]           unpack_value;

    l15_amo_lane_fmt #(
        .SWAP_ENDIANESS  (SWAP_ENDIANESS),
        .LINE_WIDTH      (LINE_WIDTH),
        .LINE_WIDTH_LOG2 (LINE_WIDTH_LOG2)
    ) u_lane_fmt (
        .operand    (bus.core_req_data),
        .req_off    (bus.core_req_addr[LINE_WIDTH_LOG2-1:0]),
        .req_size   (bus.core_req_size),
        .req_line   (pack_line),
        .resp_line  (bus.l2_resp_data),
        .resp_off   (addr_q[LINE_WIDTH_LOG2-1:0]),
        .resp_size  (size_q),
        .resp_value (unpack_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_q        <= '0;
            addr_q      <= '0;
            size_q      <= '0;
            line_q      <= '0;
            resp_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            line_q      <= line_d;
            resp_data_q <= resp_data_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        size_d      = size_q;
        line_d      = line_q;
        resp_data_d = resp_data_q;
        err_d       = err_q;
        case (state_q)
            StIdle: begin
                if (bus.core_req_val) begin
                    op_d   = bus.core_req_op;
                    addr_d = bus.core_req_addr;
                    size_d = bus.core_req_size;
                    line_d = pack_line;
                    if (size_misaligned(bus.core_req_size, bus.core_req_addr[2:0])) begin
                        resp_data_d = '0;
                        err_d       = 1'b1;
                        state_d     = StResp;
                    end else begin
                        err_d   = 1'b0;
                        state_d = StReq;
                    end
                end
            end
            StReq:  if (bus.l2_req_rdy) state_d = StWait;
            StWait: begin
                if (bus.l2_resp_val) begin
                    resp_data_d = unpack_value;
                    state_d     = StResp;
                end
            end
            StResp: if (bus.core_resp_rdy) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign bus.core_req_rdy   = (state_q == StIdle);
    assign bus.l2_req_val     = (state_q == StReq);
    assign bus.l2_resp_rdy    = (state_q == StWait);
    assign bus.core_resp_val  = (state_q == StResp);
    assign bus.l2_req_op      = op_q;
    assign bus.l2_req_addr    = addr_q;
    assign bus.l2_req_size    = size_q;
    assign bus.l2_req_data    = line_q;
    assign bus.core_resp_data = resp_data_q;
    assign bus.core_resp_err  = err_q;
endmodule

// File: tb/tb_l15_amo_initiator.sv
// Bench: two initiators (byte swap on/off) driven in lockstep and checked against a line model.
module tb_l15_amo_initiator;
    import l15_amo_initiator_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   hs = 0;

    always #5 clk = ~clk;

    l15_amo_initiator_if #(.LINE_WIDTH(128)) b1 ();
    l15_amo_initiator_if #(.LINE_WIDTH(128)) b0 ();

    l15_amo_initiator #(.SWAP_ENDIANESS(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    l15_amo_initiator #(.SWAP_ENDIANESS(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

    always @(posedge clk) if (b1.l2_req_val && b1.l2_req_rdy) hs <= hs + 1;

    typedef struct {
        logic [3:0]   op;
        logic [39:0]  addr;
        logic [2:0]   size;
        logic [63:0]  data;
        logic [127:0] rline;
        logic [127:0] el1, el0;
        logic [63:0]  ev1, ev0;
        logic         err;
    } vec_t;

    vec_t vecs[7];

    // Reference model: byte arithmetic on a 128-bit line.
    function automatic int nbytes(input logic [2:0] s);
        case (s)
            3'd1: return 1;
            3'd2: return 2;
            3'd3: return 4;
            3'd4: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic logic [63:0] rev(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(7-i) +: 8];
        return r;
    endfunction

    function automatic logic m_err(input logic [39:0] a, input logic [2:0] s);
        int nb = nbytes(s);
        return (nb == 0) || ((a % nb) != 0);
    endfunction

    function automatic logic [127:0] m_pack(input bit swap, input logic [63:0] op,
                                            input logic [39:0] a, input logic [2:0] s);
        int nb = nbytes(s);
        int lane = int'(a[6:3]);
        logic [63:0] d;
        d = (nb == 8) ? op : op % (64'd1 << (8 * nb));
        d = d << (8 * int'(a[2:0]));
        if (swap) d = rev(d);
        return (lane < 2) ? (128'(d) << (64 * lane)) : 128'd0;
    endfunction

    function automatic logic [63:0] m_unpack(input bit swap, input logic [127:0] line,
                                             input logic [39:0] a, input logic [2:0] s);
        int nb = nbytes(s);
        int lane = int'(a[6:3]);
        logic [63:0] d;
        logic [63:0] lim;
        d = (lane < 2) ? line[64*lane +: 64] : 64'd0;
        if (swap) d = rev(d);
        d = d >> (8 * int'(a[2:0]));
        if (nb < 8) begin
            lim = 64'd1 << (8 * nb);
            d = d % lim;
            if (d >= (lim >> 1)) d = d - lim;
        end
        return d;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [3:0] op, input logic [39:0] a,
                           input logic [2:0] s, input logic [63:0] d);
        b1.core_req_val = v; b1.core_req_op = op; b1.core_req_addr = a;
        b1.core_req_size = s; b1.core_req_data = d;
        b0.core_req_val = v; b0.core_req_op = op; b0.core_req_addr = a;
        b0.core_req_size = s; b0.core_req_data = d;
    endtask

    task automatic set_l2(input logic rrdy, input logic rval, input logic [127:0] rd);
        b1.l2_req_rdy = rrdy; b1.l2_resp_val = rval; b1.l2_resp_data = rd;
        b0.l2_req_rdy = rrdy; b0.l2_resp_val = rval; b0.l2_resp_data = rd;
    endtask

    task automatic set_crdy(input logic r);
        b1.core_resp_rdy = r;
        b0.core_resp_rdy = r;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req_rdy"}, {b1.core_req_rdy, b0.core_req_rdy}, 2'b11);
        chk({tag, " l2_req_val"}, {b1.l2_req_val, b0.l2_req_val}, 2'b00);
        chk({tag, " l2_resp_rdy"}, {b1.l2_resp_rdy, b0.l2_resp_rdy}, 2'b00);
        chk({tag, " resp_val/err"}, {b1.core_resp_val, b0.core_resp_val,
                                     b1.core_resp_err, b0.core_resp_err}, 4'b0000);
        chk({tag, " regs"}, {b1.l2_req_data, b0.l2_req_data}, 256'd0);
        chk({tag, " resp_data"}, {b1.core_resp_data, b0.core_resp_data,
                                  b1.l2_req_addr, b1.l2_req_op, b1.l2_req_size}, '0);
    endtask

    task automatic run_txn(input logic [3:0] op, input logic [39:0] a, input logic [2:0] s,
                           input logic [63:0] d, input logic [127:0] rline,
                           input logic [127:0] el1, input logic [127:0] el0,
                           input logic [63:0] ev1, input logic [63:0] ev0, input logic eerr,
                           input int rs, input int ps, input bit early);
        int hs0 = hs;
        chk("req_rdy idle", {b1.core_req_rdy, b0.core_req_rdy}, 2'b11);
        set_crdy(early);
        set_req(1'b1, op, a, s, d);
        step();
        set_req(1'b0, 4'd0, 40'd0, 3'd0, 64'd0);
        if (!eerr) begin
            chk("l2_req_val", {b1.l2_req_val, b0.l2_req_val, b1.core_req_rdy, b0.core_req_rdy},
                4'b1100);
            chk("l2_req fields", {b1.l2_req_op, b1.l2_req_addr, b1.l2_req_size,
                                  b0.l2_req_op, b0.l2_req_addr, b0.l2_req_size},
                {op, a, s, op, a, s});
            chk("l2_req_data", {b1.l2_req_data, b0.l2_req_data}, {el1, el0});
            for (int i = 0; i < rs; i++) begin
                step();
                chk("req hold", {b1.l2_req_val, b0.l2_req_val, b1.core_req_rdy, b1.l2_req_op,
                                 b1.l2_req_addr, b1.l2_req_size}, {3'b110, op, a, s});
                chk("req hold data", {b1.l2_req_data, b0.l2_req_data}, {el1, el0});
            end
            set_l2(1'b1, 1'b0, 128'd0);
            step();
            set_l2(1'b0, 1'b0, 128'd0);
            chk("wait state", {b1.l2_req_val, b0.l2_req_val, b1.l2_resp_rdy, b0.l2_resp_rdy,
                               b1.core_resp_val, b0.core_resp_val}, 6'b001100);
            set_l2(1'b0, 1'b1, rline);
            step();
            set_l2(1'b0, 1'b0, 128'd0);
        end else begin
            chk("err no l2", {b1.l2_req_val, b0.l2_req_val}, 2'b00);
        end
        chk("resp_val/err", {b1.core_resp_val, b0.core_resp_val, b1.core_resp_err,
                             b0.core_resp_err, b1.core_req_rdy}, {2'b11, eerr, eerr, 1'b0});
        chk("resp_data", {b1.core_resp_data, b0.core_resp_data}, {ev1, ev0});
        if (!early) begin
            for (int i = 0; i < ps; i++) begin
                step();
                chk("resp hold", {b1.core_resp_val, b0.core_resp_val, b1.core_resp_err,
                                  b1.core_req_rdy, b1.l2_req_val}, {2'b11, eerr, 2'b00});
                chk("resp hold data", {b1.core_resp_data, b0.core_resp_data}, {ev1, ev0});
            end
        end
        set_crdy(1'b1);
        step();
        set_crdy(1'b0);
        chk("resp done", {b1.core_resp_val, b0.core_resp_val, b1.core_req_rdy, b0.core_req_rdy},
            4'b0011);
        chk("l2 req count", 256'(hs - hs0), eerr ? 256'd0 : 256'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{L2_AMO_ALU_ADD, 40'h0C, MSG_DATA_SIZE_4B, 64'h8000_0001,
                    {64'h0000_0000_F0DE_BC9A, 64'd0},
                    {64'h0000_0000_0100_0080, 64'd0}, {64'h8000_0001_0000_0000, 64'd0},
                    64'hFFFF_FFFF_9ABC_DEF0, 64'd0, 1'b0};
        vecs[1] = '{L2_AMO_ALU_OR, 40'h3, MSG_DATA_SIZE_1B, 64'hA5,
                    128'h7F00_0000,
                    {64'd0, 64'h0000_00A5_0000_0000}, {64'd0, 64'h0000_0000_A500_0000},
                    64'd0, 64'h7F, 1'b0};
        vecs[2] = '{L2_AMO_ALU_MAX, 40'h8, MSG_DATA_SIZE_8B, 64'h0123_4567_89AB_CDEF,
                    {64'hEFCD_AB89_6745_2301, 64'd0},
                    {64'hEFCD_AB89_6745_2301, 64'd0}, {64'h0123_4567_89AB_CDEF, 64'd0},
                    64'h0123_4567_89AB_CDEF, 64'hEFCD_AB89_6745_2301, 1'b0};
        vecs[3] = '{L2_AMO_ALU_XOR, 40'h5, MSG_DATA_SIZE_2B, 64'h1234,
                    128'd0, 128'd0, 128'd0, 64'd0, 64'd0, 1'b1};
        vecs[4] = '{L2_AMO_ALU_MINU, 40'h6, MSG_DATA_SIZE_2B, 64'hFFFF_8001,
                    {64'd0, 64'h0000_0000_0000_0180},
                    {64'd0, 64'h0000_0000_0000_0180}, {64'd0, 64'h8001_0000_0000_0000},
                    64'hFFFF_FFFF_FFFF_8001, 64'd0, 1'b0};
        vecs[5] = '{L2_AMO_ALU_AND, 40'h4, MSG_DATA_SIZE_8B, 64'h55,
                    128'd0, 128'd0, 128'd0, 64'd0, 64'd0, 1'b1};
        vecs[6] = '{L2_AMO_ALU_CAS1, 40'h0, MSG_DATA_SIZE_0B, 64'h55,
                    128'd0, 128'd0, 128'd0, 64'd0, 64'd0, 1'b1};

        set_req(1'b0, 4'd0, 40'd0, 3'd0, 64'd0);
        set_l2(1'b0, 1'b0, 128'd0);
        set_crdy(1'b0);
        step();
        step();
        chk_reset_outputs("reset");
        #3 rst_n = 1'b1;
        step();
        chk_reset_outputs("post-reset");

        foreach (vecs[i])
            run_txn(vecs[i].op, vecs[i].addr, vecs[i].size, vecs[i].data, vecs[i].rline,
                    vecs[i].el1, vecs[i].el0, vecs[i].ev1, vecs[i].ev0, vecs[i].err, 0, 0, 0);

        // Backpressure on both the L2 request and the core response.
        run_txn(vecs[0].op, vecs[0].addr, vecs[0].size, vecs[0].data, vecs[0].rline,
                vecs[0].el1, vecs[0].el0, vecs[0].ev1, vecs[0].ev0, 1'b0, 5, 4, 0);
        // core_resp_rdy already high when the result appears.
        run_txn(vecs[4].op, vecs[4].addr, vecs[4].size, vecs[4].data, vecs[4].rline,
                vecs[4].el1, vecs[4].el0, vecs[4].ev1, vecs[4].ev0, 1'b0, 0, 0, 1);
        run_txn(vecs[3].op, vecs[3].addr, vecs[3].size, vecs[3].data, vecs[3].rline,
                vecs[3].el1, vecs[3].el0, vecs[3].ev1, vecs[3].ev0, 1'b1, 0, 0, 1);

        // Reset while waiting for L2, then a stale response.
        set_req(1'b1, vecs[0].op, vecs[0].addr, vecs[0].size, vecs[0].data);
        step();
        set_req(1'b0, 4'd0, 40'd0, 3'd0, 64'd0);
        set_l2(1'b1, 1'b0, 128'd0);
        step();
        set_l2(1'b0, 1'b0, 128'd0);
        chk("mid wait", {b1.l2_resp_rdy, b0.l2_resp_rdy}, 2'b11);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async reset");
        step();
        #3 rst_n = 1'b1;
        set_l2(1'b0, 1'b1, vecs[0].rline);
        step();
        step();
        chk_reset_outputs("stale resp");
        set_l2(1'b0, 1'b0, 128'd0);
        run_txn(vecs[2].op, vecs[2].addr, vecs[2].size, vecs[2].data, vecs[2].rline,
                vecs[2].el1, vecs[2].el0, vecs[2].ev1, vecs[2].ev0, 1'b0, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            logic [63:0]  d;
            logic [39:0]  a;
            logic [2:0]   s;
            logic [3:0]   op;
            logic [127:0] rl;
            logic         e;
            int           nb;
            d  = {$urandom, $urandom};
            a  = 40'({$urandom, $urandom});
            a[6:4] = 3'd0;
            s  = 3'($urandom_range(0, 5));
            op = 4'($urandom_range(0, 10));
            rl = {$urandom, $urandom, $urandom, $urandom};
            nb = nbytes(s);
            if (nb != 0 && $urandom_range(0, 3) != 0) a = a - 40'(a % nb);
            e = m_err(a, s);
            run_txn(op, a, s, d, rl, m_pack(1, d, a, s), m_pack(0, d, a, s),
                    e ? 64'd0 : m_unpack(1, rl, a, s), e ? 64'd0 : m_unpack(0, rl, a, s), e,
                    $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
